// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default widths for the memory arbiter slice.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle of the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int GNT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0]        resp_valid_o;
  logic [NUM_REQ-1:0]        resp_ready_i;
  logic [DATA_W-1:0]         resp_data_o;
  logic                      mem_req_valid_o;
  logic                      mem_req_ready_i;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic                      mem_resp_valid_i;
  logic                      mem_resp_ready_o;
  logic [DATA_W-1:0]         mem_data_i;
  logic                      busy_o;
  logic [GNT_W-1:0]          gnt_id_o;

  modport slave (
    input  req_valid_i, req_addr_i, resp_ready_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_data_o,
    output mem_req_valid_o, mem_addr_o, mem_resp_ready_o,
    output busy_o, gnt_id_o
  );

  modport master (
    output req_valid_i, req_addr_i, resp_ready_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
    input  mem_req_valid_o, mem_addr_o, mem_resp_ready_o,
    input  busy_o, gnt_id_o
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr,
// wrapping modulo NUM_REQ. Kept generic so other arbiters can reuse it.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int GNT_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   rr_ptr,
  output logic [GNT_W-1:0]   winner,
  output logic               any_valid
);

  // Walk the requesters starting at rr_ptr and keep the first one found.
  always_comb begin
    logic [GNT_W:0] idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (GNT_W+1)'(i);
      if (idx >= (GNT_W+1)'(NUM_REQ)) begin
        idx = idx - (GNT_W+1)'(NUM_REQ);
      end
      if (!any_valid && req[idx[GNT_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[GNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-outstanding word-read memory port
// between NUM_REQ page-table walkers. One transaction runs end to end at a
// time; the response is buffered and returned only to the granted requester.
// Every output is decoded from registered state so no input reaches an
// output combinationally.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic       clk,
  input logic       rst,
  mem_arbiter_if.slave bus
);

  localparam int GNT_W = $clog2(NUM_REQ);

  arb_state_e        state, state_n;
  logic [GNT_W-1:0]  rr_ptr, rr_ptr_n;
  logic [GNT_W-1:0]  gnt, gnt_n;
  logic [GNT_W-1:0]  winner;
  logic              any_valid;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [ADDR_W-1:0] req_addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_onehot;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_picker (
    .req       (bus.req_valid_i),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign gnt_onehot   = NUM_REQ'(1) << gnt;
  assign bus.gnt_id_o = gnt;

  // Unpack the flattened address bus so the granted address can be indexed.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr_arr[i] = bus.req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // State, pointer, grant and buffered address/data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      gnt    <= gnt_n;
      addr_q <= addr_n;
      data_q <= data_n;
    end
  end

  // Next-state logic; the pointer moves only when a response is delivered.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    gnt_n    = gnt;
    addr_n   = addr_q;
    data_n   = data_q;
    case (state)
      IDLE: begin
        if (any_valid) begin
          gnt_n   = winner;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.req_valid_i[gnt]) begin
          addr_n  = req_addr_arr[gnt];
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready_i) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid_i) begin
          data_n  = bus.mem_data_i;
          state_n = DELIVER;
        end
      end
      DELIVER: begin
        if (bus.resp_ready_i[gnt]) begin
          rr_ptr_n = (gnt == GNT_W'(NUM_REQ-1)) ? '0 : gnt + GNT_W'(1);
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore output decode; an illegal encoding leaves every output deasserted.
  always_comb begin
    bus.req_ready_o      = '0;
    bus.resp_valid_o     = '0;
    bus.resp_data_o      = '0;
    bus.mem_req_valid_o  = 1'b0;
    bus.mem_addr_o       = '0;
    bus.mem_resp_ready_o = 1'b0;
    bus.busy_o           = 1'b0;
    case (state)
      GRANT: begin
        bus.req_ready_o = gnt_onehot;
        bus.busy_o      = 1'b1;
      end
      ISSUE: begin
        bus.mem_req_valid_o = 1'b1;
        bus.mem_addr_o      = addr_q;
        bus.busy_o          = 1'b1;
      end
      WAIT: begin
        bus.mem_resp_ready_o = 1'b1;
        bus.busy_o           = 1'b1;
      end
      DELIVER: begin
        bus.resp_valid_o = gnt_onehot;
        bus.resp_data_o  = data_q;
        bus.busy_o       = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester and memory models drive the
// interface, stimulus pushes hand-computed responses, a monitor pops them.
module tb_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } req_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  req_t pend0[$];
  req_t pend1[$];
  exp_t exp_q[$];

  req_t cur0, cur1;
  bit   active0 = 0, active1 = 0;
  bit   hs0, hs1;
  int   drops_done = 0;

  logic [1:0]  drv_valid    = 2'b00;
  logic [63:0] drv_addr     = '0;
  logic [1:0]  drv_resp_rdy = 2'b11;
  logic        mem_req_rdy  = 1'b1;

  logic        mrv   = 1'b0;
  logic [31:0] mdata = '0;
  logic [31:0] mem_addr_seen = '0;
  bit          mreq_hs, mresp_hs, mpend;
  int          mcnt    = 0;
  int          mem_lat = 0;

  int busy_cnt = 0, mreq_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, onehot_err = 0;

  mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_valid_i      = drv_valid;
  assign bus.req_addr_i       = drv_addr;
  assign bus.resp_ready_i     = drv_resp_rdy;
  assign bus.mem_req_ready_i  = mem_req_rdy;
  assign bus.mem_resp_valid_i = mrv;
  assign bus.mem_data_i       = mdata;

  always #5 clk = ~clk;

  // Page table contents seen by the memory model.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h0000_0400: return 32'h0000_0801;
      32'h0000_0404: return 32'h1234_0007;
      32'h0000_0800: return 32'h1000_000F;
      32'h0000_0808: return 32'h1200_0007;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] addr, input bit drop,
                               input bit has_exp, input logic [31:0] data);
    req_t r;
    exp_t e;
    r.addr = addr;
    r.drop = drop;
    if (id == 0) pend0.push_back(r);
    else         pend1.push_back(r);
    if (has_exp) begin
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_req_ready"},  32'(bus.req_ready_o), 32'h0);
    checkOutput({pfx, "_resp_valid"}, 32'(bus.resp_valid_o), 32'h0);
    checkOutput({pfx, "_resp_data"},  bus.resp_data_o, 32'h0);
    checkOutput({pfx, "_mem_req"},    32'(bus.mem_req_valid_o), 32'h0);
    checkOutput({pfx, "_mem_addr"},   bus.mem_addr_o, 32'h0);
    checkOutput({pfx, "_mem_resp_rdy"}, 32'(bus.mem_resp_ready_o), 32'h0);
    checkOutput({pfx, "_busy"},       32'(bus.busy_o), 32'h0);
    checkOutput({pfx, "_gnt_id"},     32'(bus.gnt_id_o), 32'h0);
  endtask

  task automatic resetCounters();
    busy_cnt = 0;
    mreq_cnt = 0;
    rdy0_cnt = 0;
    rdy1_cnt = 0;
  endtask

  task automatic waitDone(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && pend0.size() == 0 && pend1.size() == 0 &&
          !active0 && !active1 && !bus.busy_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got pending=%0d, wanted 0", name, exp_q.size());
    end
  endtask

  // Requester model: holds valid until accepted, or drops it while granted.
  always begin
    @(negedge clk);
    hs0 = 0;
    hs1 = 0;
    if (rst) begin
      active0 = 0;
      active1 = 0;
    end else begin
      if (active0 && bus.req_ready_o[0]) begin
        if (cur0.drop) begin active0 = 0; drops_done++; end
        else hs0 = 1;
      end
      if (active1 && bus.req_ready_o[1]) begin
        if (cur1.drop) begin active1 = 0; drops_done++; end
        else hs1 = 1;
      end
    end
    drv_valid = {active1, active0};
    @(posedge clk); #1;
    if (hs0) active0 = 0;
    if (hs1) active1 = 0;
    if (!rst && !active0 && pend0.size() > 0) begin cur0 = pend0.pop_front(); active0 = 1; end
    if (!rst && !active1 && pend1.size() > 0) begin cur1 = pend1.pop_front(); active1 = 1; end
    drv_valid = {active1, active0};
    drv_addr  = {cur1.addr, cur0.addr};
  end

  // Memory model: accepts a request, answers after mem_lat extra cycles.
  always begin
    @(negedge clk);
    if (rst) begin
      mreq_hs  = 0;
      mresp_hs = 0;
      mpend    = 0;
      mrv      = 1'b0;
    end else begin
      mreq_hs  = bus.mem_req_valid_o && bus.mem_req_ready_i;
      mresp_hs = mrv && bus.mem_resp_ready_o;
      if (mreq_hs) mem_addr_seen = bus.mem_addr_o;
    end
    @(posedge clk); #1;
    if (rst) begin
      mpend = 0;
      mrv   = 1'b0;
    end else begin
      if (mresp_hs) mrv = 1'b0;
      if (mreq_hs) begin mpend = 1; mcnt = mem_lat; end
      if (mpend) begin
        if (mcnt == 0) begin
          mpend = 0;
          mrv   = 1'b1;
          mdata = mem_read(mem_addr_seen);
        end else begin
          mcnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake, tallies activity.
  always begin
    logic [1:0] hsv;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      hsv = bus.resp_valid_o & bus.resp_ready_i;
      if (hsv != 2'b00) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'(hsv), 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_valid", 32'(bus.resp_valid_o), 32'(1) << e.id);
          checkOutput("resp_data", bus.resp_data_o, e.data);
          checkOutput("gnt_id", 32'(bus.gnt_id_o), 32'(e.id));
        end
      end
      if (bus.busy_o) busy_cnt++;
      if (bus.mem_req_valid_o) mreq_cnt++;
      if (bus.req_ready_o[0]) rdy0_cnt++;
      if (bus.req_ready_o[1]) rdy1_cnt++;
      if ($countones(bus.req_ready_o) > 1 || $countones(bus.resp_valid_o) > 1) onehot_err++;
    end
  end

  // Directed sequence.
  initial begin
    bit seen;
    int d0;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    // Single read by requester 0; requester 1 never granted, 5-cycle transaction.
    @(negedge clk); #1;
    resetCounters();
    applyStimulus(0, 32'h400, 0, 1, 32'h0000_0801);
    waitDone("single");
    checkOutput("single_rdy1_never", 32'(rdy1_cnt), 32'h0);
    checkOutput("single_busy_cycles", 32'(busy_cnt), 32'd4);

    // Out-of-range read by requester 1 with a stalled memory request port.
    mem_req_rdy = 1'b0;
    applyStimulus(1, 32'h1000, 0, 1, 32'h0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.mem_req_valid_o) begin seen = 1; break; end
    end
    checkOutput("oor_mem_req_seen", 32'(seen), 32'h1);
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("oor_mem_req_hold", 32'(bus.mem_req_valid_o), 32'h1);
      checkOutput("oor_mem_addr", bus.mem_addr_o, 32'h1000);
    end
    @(posedge clk); #1;
    mem_req_rdy = 1'b1;
    waitDone("oor");

    // Both requesters in the same cycle with the pointer at 0.
    @(negedge clk); #1;
    applyStimulus(0, 32'h400, 0, 1, 32'h0000_0801);
    applyStimulus(1, 32'h404, 0, 1, 32'h1234_0007);
    waitDone("both");

    // Repeat to show the pointer wrapped back to requester 0.
    @(negedge clk); #1;
    applyStimulus(0, 32'h808, 0, 1, 32'h1200_0007);
    applyStimulus(1, 32'h800, 0, 1, 32'h1000_000F);
    waitDone("both_again");

    // Requester 1 holds its response ready low; requester 0 waits meanwhile.
    @(posedge clk); #1;
    drv_resp_rdy = 2'b01;
    @(negedge clk); #1;
    applyStimulus(1, 32'h800, 0, 1, 32'h1000_000F);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.resp_valid_o[1]) begin seen = 1; break; end
    end
    checkOutput("stall_resp_seen", 32'(seen), 32'h1);
    applyStimulus(0, 32'h404, 0, 1, 32'h1234_0007);
    resetCounters();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checkOutput("stall_valid", 32'(bus.resp_valid_o), 32'h2);
      checkOutput("stall_data", bus.resp_data_o, 32'h1000_000F);
    end
    checkOutput("stall_no_mem_req", 32'(mreq_cnt), 32'h0);
    checkOutput("stall_no_grant", 32'(rdy0_cnt), 32'h0);
    @(posedge clk); #1;
    drv_resp_rdy = 2'b11;
    waitDone("stall");

    // Bring the pointer back to 0 before the drop case.
    @(negedge clk); #1;
    applyStimulus(1, 32'h808, 0, 1, 32'h1200_0007);
    waitDone("ptr_zero");

    // Requester 0 drops valid while granted: no memory access, pointer kept.
    @(negedge clk); #1;
    resetCounters();
    d0 = drops_done;
    applyStimulus(0, 32'h400, 1, 0, 32'h0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (drops_done != d0) begin seen = 1; break; end
    end
    checkOutput("drop_seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("drop_no_mem_req", 32'(mreq_cnt), 32'h0);
    checkOutput("drop_busy_cycles", 32'(busy_cnt), 32'h1);
    checkOutput("drop_one_grant", 32'(rdy0_cnt), 32'h1);
    checkOutput("drop_idle", 32'(bus.busy_o), 32'h0);
    applyStimulus(0, 32'h400, 0, 1, 32'h0000_0801);
    applyStimulus(1, 32'h404, 0, 1, 32'h1234_0007);
    waitDone("after_drop");

    // Reset pulsed while waiting on a slow memory; the read is lost.
    @(negedge clk); #1;
    mem_lat = 6;
    applyStimulus(0, 32'h800, 0, 0, 32'h0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.mem_resp_ready_o) begin seen = 1; break; end
    end
    checkOutput("rst_wait_seen", 32'(seen), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk); #1;
    mem_lat = 0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("post_rst_idle", 32'(bus.busy_o), 32'h0);
    applyStimulus(0, 32'h808, 0, 1, 32'h1200_0007);
    waitDone("post_rst");

    checkOutput("onehot", 32'(onehot_err), 32'h0);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter sharing the single-outstanding word-read memory port between NUM_REQ requesters (e.g. ITLB PTW, DTLB PTW).
- Sits between the page-table walkers and the memory block.
- Serialises one full request/response transaction at a time.
- Buffers the response and routes it back to the granted requester only.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- ADDR_W, 32, byte address width
- DATA_W, 32, read data width
- GNT_W, $clog2(NUM_REQ), width of grant index (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid; must stay high and stable until req_ready_o
- req_ready_o  out  NUM_REQ  per-requester request accept, one-hot or zero
- req_addr_i  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- resp_valid_o  out  NUM_REQ  per-requester response valid, one-hot or zero
- resp_ready_i  in  NUM_REQ  per-requester response ready
- resp_data_o  out  DATA_W  response data, shared by all requesters; meaningful only where resp_valid_o is set
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_addr_o  out  ADDR_W  memory byte address
- mem_resp_valid_i  in  1  memory response valid
- mem_resp_ready_o  out  1  memory response ready
- mem_data_i  in  DATA_W  memory read data
- busy_o  out  1  high whenever state != IDLE
- gnt_id_o  out  GNT_W  index of the current or last grant

Behaviour:
- All flops use posedge clk or posedge rst.
- All outputs are Moore: decoded from registered state, grant and data only. There is no combinational input-to-output path.
- Reset values: state=IDLE, rr_ptr=0, gnt=0, addr_q=0, data_q=0. All valid/ready outputs 0, resp_data_o=0, mem_addr_o=0, busy_o=0.
- IDLE:
  - If any req_valid_i bit is set, winner = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - gnt<=winner, go to GRANT.
- GRANT:
  - req_ready_o[gnt]=1.
  - If req_valid_i[gnt]: addr_q<=req_addr_i[gnt], go to ISSUE.
  - Otherwise (protocol violation, valid dropped): go to IDLE; rr_ptr unchanged; no memory access.
- ISSUE:
  - mem_req_valid_o=1, mem_addr_o=addr_q.
  - On mem_req_ready_i, go to WAIT. Valid is deasserted the following cycle.
- WAIT:
  - mem_resp_ready_o=1.
  - On mem_resp_valid_i: data_q<=mem_data_i, go to DELIVER.
- DELIVER:
  - resp_valid_o[gnt]=1, resp_data_o=data_q.
  - On resp_ready_i[gnt]: rr_ptr<=(gnt==NUM_REQ-1)?0:gnt+1, go to IDLE.
- Latency:
  - Requester accept occurs 1 cycle after valid is seen in IDLE.
  - The memory sees the request 1 cycle after that.
  - The response reaches the requester 1 cycle after the memory response handshake.
- Fairness:
  - The pointer advances only on a completed transaction.
  - A requester that continuously asserts valid is served within NUM_REQ transactions.
- Non-granted requesters get req_ready_o=0 and resp_valid_o=0 at all times.
- Requests arriving in any state other than IDLE are ignored until the next IDLE.
- resp_ready_i of non-granted requesters is ignored.
- Illegal state encoding goes to IDLE with all outputs deasserted.
- Reset asserted mid-transaction:
  - Immediate return to reset values; the in-flight transaction is dropped with no response.
  - The memory block shares rst, so both sides restart clean.
- Minimum transaction length: 5 cycles with an always-ready memory and requester.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, GRANT, ISSUE, WAIT, DELIVER (3-bit encoding)
  - ADDR_W / DATA_W defaults
- One combinational sub-module, rr_picker (inputs: req vector, rr_ptr; outputs: winner index, any_valid), reused by future arbiters.

Test Plan:
- Single requester 0 reads 0x00000400 with the memory-initialised page table:
  - resp_valid_o=2'b01, resp_data_o=0x00000801.
  - req_ready_o[1] never high.
- Both requesters valid in the same cycle (req0 addr 0x400, req1 addr 0x404), rr_ptr=0:
  - req0 served first with 0x00000801.
  - req1 served next with 0x12340007.
  - rr_ptr ends at 0.
- Requester 1 holds resp_ready_i low for 10 cycles:
  - resp_valid_o[1] and data 0x1000000F (addr 0x800) stay stable.
  - mem_req_valid_o stays 0 and no new grant is made until the ready handshake.
- Requester 0 drops valid in GRANT:
  - arbiter returns to IDLE, no mem_req_valid_o pulse, rr_ptr unchanged.
  - A subsequent req1 to 0x404 completes with 0x12340007.
- Out-of-range address 0x00001000 from requester 1: response 0x00000000, normal completion.
- rst pulsed asynchronously while in WAIT:
  - all outputs 0 within the same cycle, state IDLE.
  - A subsequent read of 0x808 returns 0x12000007.
